// File: rtl/sync_frame_tx_pkg.sv
// Shared definitions for both ends of the 1011-sync serial link.
// Holds the FSM encoding, default sync pattern and counter sizing helper.
package sync_frame_tx_pkg;

    localparam int SYNC_W_DEF = 4;
    localparam logic [SYNC_W_DEF-1:0] SYNC_PATTERN_DEF = 4'b1011;

    // Gray-style encoding, matching the receive-side detector
    typedef enum logic [2:0] {
        IDLE = 3'b000,
        SYNC = 3'b001,
        DATA = 3'b011,
        PAR  = 3'b010,
        GAP  = 3'b110
    } state_e;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = 1;
        if (a > m) m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/sync_frame_tx_piso.sv
// Parallel-in serial-out register; MSB is presented first, shifts toward MSB.
// Load has priority over shift; contents clear on reset.
module piso_shift #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [W-1:0] din_i,
    output logic         msb_o
);

    logic [W-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = din_i;
        end else if (shift_i) begin
            data_d = data_q << 1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign msb_o = data_q[W-1];

endmodule

// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: sync pattern, data MSB first, optional parity, idle gap.
// First sync bit appears the cycle after accept; din_ready low from accept until the gap ends.
module sync_frame_tx
    import sync_frame_tx_pkg::*;
#(
    parameter int                DATA_W       = 8,
    parameter int                SYNC_W       = SYNC_W_DEF,
    parameter logic [SYNC_W-1:0] SYNC_PATTERN = SYNC_PATTERN_DEF,
    parameter bit                PARITY_EN    = 1'b1,
    parameter bit                PARITY_ODD   = 1'b0,
    parameter int                GAP_CYCLES   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              sout,
    output logic              frame_start,
    output logic              busy
);

    localparam int CW = cnt_width(SYNC_W, DATA_W, GAP_CYCLES);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          parity_q, parity_d;
    logic          sout_q, sout_d;
    logic          fs_q, fs_d;
    logic          rdy_q, rdy_d;
    logic          accept;
    logic          cnt_zero;
    logic          load;
    logic          shift;
    logic          data_msb;
    logic          sync_bit;

    assign accept   = (state_q == IDLE) && rdy_q && din_valid;
    assign cnt_zero = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            parity_q <= 1'b0;
            sout_q   <= 1'b0;
            fs_q     <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            parity_q <= parity_d;
            sout_q   <= sout_d;
            fs_q     <= fs_d;
            rdy_q    <= rdy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        parity_d = parity_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = SYNC;
                    cnt_d    = CW'(SYNC_W - 1);
                    parity_d = (^din) ^ PARITY_ODD;
                end
            end
            SYNC: begin
                if (cnt_zero) begin
                    state_d = DATA;
                    cnt_d   = CW'(DATA_W - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DATA: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (PARITY_EN) begin
                    state_d = PAR;
                end else if (GAP_CYCLES > 0) begin
                    state_d = GAP;
                    cnt_d   = CW'(GAP_CYCLES - 1);
                end else begin
                    state_d = IDLE;
                end
            end
            PAR: begin
                if (GAP_CYCLES > 0) begin
                    state_d = GAP;
                    cnt_d   = CW'(GAP_CYCLES - 1);
                end else begin
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (cnt_zero) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // sout is registered, so its next value is chosen from the next state
    always_comb begin
        sync_bit = 1'b0;
        for (int i = 0; i < SYNC_W; i++) begin
            if (cnt_d == CW'(i)) sync_bit = SYNC_PATTERN[i];
        end
        case (state_d)
            SYNC:    sout_d = sync_bit;
            DATA:    sout_d = data_msb;
            PAR:     sout_d = parity_d;
            default: sout_d = 1'b0;
        endcase
        fs_d  = accept;
        rdy_d = (state_d == IDLE);
        load  = accept;
        shift = (state_d == DATA);
    end

    piso_shift #(
        .W (DATA_W)
    ) u_piso (
        .clk_i   (clk),
        .rst_ni  (rst),
        .load_i  (load),
        .shift_i (shift),
        .din_i   (din),
        .msb_o   (data_msb)
    );

    assign sout        = sout_q;
    assign frame_start = fs_q;
    assign din_ready   = rdy_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_sync_frame_tx.sv
// Directed bench for sync_frame_tx: default build plus odd-parity, no-parity and zero-gap builds.
// Includes a small 1011 detector model on the serial line for loopback checks.
module tb_sync_frame_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready, sout, frame_start, busy;

    logic [7:0] adin [3];
    logic [2:0] avld;
    logic [2:0] ardy, asout, afs, abusy;

    logic [2:0] det_sh;
    logic       det;

    int n_chk = 0;
    int n_bad = 0;

    logic [15:0] sv, fv, bv, rv, dv;
    logic [30:0] bs, bf, br;

    always #5 clk = ~clk;

    sync_frame_tx u_dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .sout(sout), .frame_start(frame_start), .busy(busy)
    );

    sync_frame_tx #(.PARITY_ODD(1'b1)) u_odd (
        .clk(clk), .rst(rst), .din(adin[0]), .din_valid(avld[0]), .din_ready(ardy[0]),
        .sout(asout[0]), .frame_start(afs[0]), .busy(abusy[0])
    );

    sync_frame_tx #(.PARITY_EN(1'b0)) u_nop (
        .clk(clk), .rst(rst), .din(adin[1]), .din_valid(avld[1]), .din_ready(ardy[1]),
        .sout(asout[1]), .frame_start(afs[1]), .busy(abusy[1])
    );

    sync_frame_tx #(.GAP_CYCLES(0)) u_g0 (
        .clk(clk), .rst(rst), .din(adin[2]), .din_valid(avld[2]), .din_ready(ardy[2]),
        .sout(asout[2]), .frame_start(afs[2]), .busy(abusy[2])
    );

    // receive-side 1011 detector: pulses the cycle after the last pattern bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            det_sh <= '0;
            det    <= 1'b0;
        end else begin
            det_sh <= {det_sh[1:0], sout};
            det    <= ({det_sh, sout} == 4'b1011);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic wait_rdy();
        for (int i = 0; i < 40 && din_ready !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        chk("rdy_wait", 32'(din_ready), 32'd1);
    endtask

    // accept w on the main DUT and record cycles 1..16 after the accepting edge
    task automatic run_frame(input logic [7:0] w,
                             output logic [15:0] s, f, b, r, d);
        wait_rdy();
        din       = w;
        din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            s[15-i] = sout;
            f[15-i] = frame_start;
            b[15-i] = busy;
            r[15-i] = din_ready;
            d[15-i] = det;
        end
    endtask

    task automatic alt_frame(input int k, input logic [7:0] w,
                             output logic [15:0] s, f, b, r);
        for (int i = 0; i < 40 && ardy[k] !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        chk("alt_rdy_wait", 32'(ardy[k]), 32'd1);
        adin[k] = w;
        avld[k] = 1'b1;
        @(posedge clk); #1;
        avld[k] = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            s[15-i] = asout[k];
            f[15-i] = afs[k];
            b[15-i] = abusy[k];
            r[15-i] = ardy[k];
        end
    endtask

    initial begin
        rst       = 1'b0;
        din       = 8'h00;
        din_valid = 1'b0;
        avld      = '0;
        for (int k = 0; k < 3; k++) adin[k] = 8'h00;

        // reset state
        #12;
        chk("rst_sout",  32'(sout),        32'd0);
        chk("rst_busy",  32'(busy),        32'd0);
        chk("rst_fs",    32'(frame_start), 32'd0);
        chk("rst_rdy",   32'(din_ready),   32'd0);
        #1 rst = 1'b1;
        #1;
        chk("rel_rdy_before_edge", 32'(din_ready), 32'd0);
        @(posedge clk); #1;
        chk("rel_rdy_after_edge", 32'(din_ready), 32'd1);

        // basic frame A5, even parity
        run_frame(8'hA5, sv, fv, bv, rv, dv);
        chk("a5_sout",  32'(sv), 32'(16'b1011_10100101_0_00_0));
        chk("a5_fs",    32'(fv), 32'(16'b1000_00000000_0_00_0));
        chk("a5_busy",  32'(bv), 32'(16'b1111_11111111_1_11_0));
        chk("a5_rdy",   32'(rv), 32'(16'b0000_00000000_0_00_1));

        // odd parity build, FF
        alt_frame(0, 8'hFF, sv, fv, bv, rv);
        chk("odd_sout", 32'(sv), 32'(16'b1011_11111111_1_00_0));
        chk("odd_fs",   32'(fv), 32'h8000);
        chk("odd_busy", 32'(bv), 32'hFFFE);
        chk("odd_rdy",  32'(rv), 32'h0001);

        // no-parity build, 00
        alt_frame(1, 8'h00, sv, fv, bv, rv);
        chk("nop_sout", 32'(sv), 32'(16'b1011_00000000_00_00));
        chk("nop_fs",   32'(fv), 32'h8000);
        chk("nop_busy", 32'(bv), 32'hFFFC);
        chk("nop_rdy",  32'(rv), 32'h0003);

        // zero-gap build, 01 (parity 1)
        alt_frame(2, 8'h01, sv, fv, bv, rv);
        chk("g0_sout", 32'(sv), 32'(16'b1011_00000001_1_000));
        chk("g0_fs",   32'(fv), 32'h8000);
        chk("g0_busy", 32'(bv), 32'hFFF8);
        chk("g0_rdy",  32'(rv), 32'h0007);

        // back-to-back with din_valid held; din changes mid-frame
        wait_rdy();
        din       = 8'h01;
        din_valid = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 31; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
            end
            bs[31-c] = sout;
            bf[31-c] = frame_start;
            br[31-c] = din_ready;
            if (c == 1)  din = 8'h80;
            if (c == 18) din = 8'hFF;
        end
        din_valid = 1'b0;
        chk("b2b_sout", 32'(bs), 32'(31'b1011_00000001_1_00_0_1011_10000000_1_00));
        chk("b2b_fs",   32'(bf), 32'(31'b1000_00000000_0_00_0_1000_00000000_0_00));
        chk("b2b_rdy",  32'(br), 32'(31'b0000_00000000_0_00_1_0000_00000000_0_00));
        @(posedge clk); #1;
        chk("b2b_end_sout", 32'(sout),      32'd0);
        chk("b2b_end_busy", 32'(busy),      32'd0);
        chk("b2b_end_rdy",  32'(din_ready), 32'd1);

        // reset during data bit 3 of C3
        wait_rdy();
        din       = 8'hC3;
        din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
        end
        chk("mid_busy_before", 32'(busy), 32'd1);
        chk("mid_sout_before", 32'(sout), 32'd0);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_sout", 32'(sout),        32'd0);
        chk("mid_rst_busy", 32'(busy),        32'd0);
        chk("mid_rst_fs",   32'(frame_start), 32'd0);
        chk("mid_rst_rdy",  32'(din_ready),   32'd0);
        @(posedge clk); #1;
        chk("mid_hold_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        #1;
        chk("mid_rel_rdy_before_edge", 32'(din_ready), 32'd0);
        @(posedge clk); #1;
        chk("mid_rel_rdy_after_edge", 32'(din_ready), 32'd1);
        chk("mid_rel_busy",           32'(busy),      32'd0);
        run_frame(8'h3C, sv, fv, bv, rv, dv);
        chk("3c_sout", 32'(sv), 32'(16'b1011_00111100_0_00_0));
        chk("3c_fs",   32'(fv), 32'h8000);
        chk("3c_rdy",  32'(rv), 32'h0001);

        // loopback into the detector model
        run_frame(8'h00, sv, fv, bv, rv, dv);
        chk("lb00_sout", 32'(sv), 32'(16'b1011_00000000_0_00_0));
        chk("lb00_det",  32'(dv), 32'(16'b0000_1000_0000_0000));
        run_frame(8'h0B, sv, fv, bv, rv, dv);
        chk("lb0b_sout", 32'(sv), 32'(16'b1011_00001011_1_00_0));
        chk("lb0b_det",  32'(dv), 32'(16'b0000_1000_0000_1000));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
